// File: rtl/lcd_field_scheduler_if.sv
// Byte stream from the field scheduler to the LCD timing engine.
// A transfer happens on a clock edge where valid and ready are both high.
interface lcd_field_scheduler_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 valid;
    logic                 ready;
    logic                 rs;
    logic [DATA_BITS-1:0] data;

    modport master (output valid, output rs, output data, input ready);
    modport slave  (input valid, input rs, input data, output ready);
endinterface

// File: rtl/lcd_field_scheduler.sv
// Round-robin sharing of the LCD byte port: each granted field becomes one
// set-cursor command followed by three ASCII decimal digits.
module lcd_field_scheduler #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_BITS  = 8,
    parameter bit BLANK_LEAD = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_value,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           busy,
    lcd_field_scheduler_if.master          out
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [DATA_BITS-1:0] HUNDRED = DATA_BITS'(100);
    localparam logic [DATA_BITS-1:0] TEN     = DATA_BITS'(10);
    localparam logic [DATA_BITS-1:0] ASCII_0 = DATA_BITS'(8'h30);
    localparam logic [DATA_BITS-1:0] SPACE   = DATA_BITS'(8'h20);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SEND_CUR,
        SEND_C,
        SEND_D,
        SEND_U
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_found;
    logic                 grant;
    logic                 xfer;
    logic [DATA_BITS-1:0] addr;
    logic [DATA_BITS-1:0] rem;
    logic [DATA_BITS-1:0] hund;
    logic [DATA_BITS-1:0] tens;
    logic [DATA_BITS-1:0] char_c;
    logic [DATA_BITS-1:0] char_d;
    logic [DATA_BITS-1:0] char_u;
    logic [DATA_BITS-1:0] addr_arr  [NUM_REQ];
    logic [DATA_BITS-1:0] value_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*DATA_BITS +: DATA_BITS];
            value_arr[i] = req_value[i*DATA_BITS +: DATA_BITS];
        end
    end

    // First requesting channel at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin : arbiter
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // No grant during the ack cycle, so a requester still holding req high
    // has a chance to see its ack before being re-arbitrated.
    assign grant = (state == IDLE) && grant_found && (ack == '0);
    assign xfer  = out.valid && out.ready;
    assign busy  = (state != IDLE);

    assign char_c = (BLANK_LEAD && hund == '0) ? SPACE : ASCII_0 + hund;
    assign char_d = (BLANK_LEAD && hund == '0 && tens == '0) ? SPACE : ASCII_0 + tens;
    assign char_u = ASCII_0 + rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out.valid  = 1'b0;
        out.rs     = 1'b0;
        out.data   = '0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (rem < TEN) begin
                    state_next = SEND_CUR;
                end
            end
            SEND_CUR: begin
                out.valid = 1'b1;
                out.data  = addr;
                if (xfer) begin
                    state_next = SEND_C;
                end
            end
            SEND_C: begin
                out.valid = 1'b1;
                out.rs    = 1'b1;
                out.data  = char_c;
                if (xfer) begin
                    state_next = SEND_D;
                end
            end
            SEND_D: begin
                out.valid = 1'b1;
                out.rs    = 1'b1;
                out.data  = char_d;
                if (xfer) begin
                    state_next = SEND_U;
                end
            end
            SEND_U: begin
                out.valid = 1'b1;
                out.rs    = 1'b1;
                out.data  = char_u;
                if (xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Field capture, one-step-per-cycle decimal conversion (rem ends as units),
    // and the ack pulse / pointer advance after the units byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            ack    <= '0;
            idx    <= '0;
            addr   <= '0;
            rem    <= '0;
            hund   <= '0;
            tens   <= '0;
        end else begin
            ack <= '0;
            if (grant) begin
                idx  <= grant_idx;
                addr <= addr_arr[grant_idx];
                rem  <= value_arr[grant_idx];
                hund <= '0;
                tens <= '0;
            end
            if (state == CONV) begin
                if (rem >= HUNDRED) begin
                    rem  <= rem - HUNDRED;
                    hund <= hund + 1'b1;
                end else if (rem >= TEN) begin
                    rem  <= rem - TEN;
                    tens <= tens + 1'b1;
                end
            end
            if (state == SEND_U && xfer) begin
                ack[idx] <= 1'b1;
                if (int'(idx) == NUM_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_field_scheduler.sv
// Bench for lcd_field_scheduler: two instances (digits shown / leading zeros
// blanked) share all inputs and are checked against a decimal-arithmetic model.
module tb_lcd_field_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [7:0]  ch_addr [3];
    int          ch_val  [3];
    logic [23:0] req_addr;
    logic [23:0] req_value;
    logic [2:0]  ack, ack_b;
    logic        busy, busy_b;
    logic        ready;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_rr     = 0;
    int cyc          = 0;
    int busy_cnt     = 0;

    typedef struct {
        int         ch;
        logic [7:0] a;
        int         v;
    } field_t;

    logic [8:0] byte_q [$];
    logic [8:0] blank_q [$];
    logic [2:0] ack_q [$];
    int         ack_t [$];
    field_t     exp_q [$];

    lcd_field_scheduler_if #(.DATA_BITS(8)) if_a ();
    lcd_field_scheduler_if #(.DATA_BITS(8)) if_b ();

    assign if_a.ready = ready;
    assign if_b.ready = ready;
    assign req_addr   = {ch_addr[2], ch_addr[1], ch_addr[0]};
    assign req_value  = {ch_val[2][7:0], ch_val[1][7:0], ch_val[0][7:0]};

    lcd_field_scheduler #(.NUM_REQ(3), .DATA_BITS(8), .BLANK_LEAD(1'b0)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_value(req_value), .ack(ack), .busy(busy), .out(if_a)
    );

    lcd_field_scheduler #(.NUM_REQ(3), .DATA_BITS(8), .BLANK_LEAD(1'b1)) dut_b (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_value(req_value), .ack(ack_b), .busy(busy_b), .out(if_b)
    );

    always #5 clk = ~clk;

    // Passive recorder of transfers, acks and busy cycles.
    always @(negedge clk) begin
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (if_a.valid === 1'b1 && ready === 1'b1) begin
            byte_q.push_back({if_a.rs, if_a.data});
            blank_q.push_back({if_b.rs, if_b.data});
        end
        if (!$isunknown(ack) && ack !== 3'b000) begin
            ack_q.push_back(ack);
            ack_t.push_back(cyc);
        end
    end

    // Expected {rs, byte} number k of a field, from plain decimal arithmetic.
    function automatic logic [8:0] model_byte(input logic [7:0] a, input int v,
                                              input int k, input bit blank);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        case (k)
            0:       return {1'b0, a};
            1:       return (blank && h == 0) ? 9'h120 : {1'b1, 8'(48 + h)};
            2:       return (blank && h == 0 && t == 0) ? 9'h120 : {1'b1, 8'(48 + t)};
            default: return {1'b1, 8'(48 + u)};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_queues();
        byte_q.delete();
        blank_q.delete();
        ack_q.delete();
        ack_t.delete();
        exp_q.delete();
        busy_cnt = 0;
    endtask

    // Requester behaviour: drop req after ack unless hold; re-randomise the
    // acked channel's value only after its ack, so exp_q holds granted values.
    task automatic run_fields(input int n, input bit hold, input bit rand_ready,
                              output bit timed_out);
        int         target;
        int         guard;
        logic [2:0] seen;
        target    = ack_q.size() + n;
        guard     = 0;
        seen      = '0;
        timed_out = 1'b0;
        while (ack_q.size() < target) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                if (seen[c]) begin
                    if (!hold) req[c] = 1'b0;
                    ch_val[c] = $urandom_range(0, 255);
                end
            end
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            sample();
            seen = ack;
            for (int c = 0; c < 3; c++) begin
                if (ack[c] === 1'b1) exp_q.push_back('{c, ch_addr[c], ch_val[c]});
            end
            guard++;
            if (guard > 40 * n + 40) begin
                timed_out = 1'b1;
                break;
            end
        end
        tick();
        req   = '0;
        ready = 1'b1;
    endtask

    task automatic test_reset();
        bit         to;
        logic [8:0] got;
        reset = 1'b1;
        req   = 3'b111;
        ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ch_addr[c] = 8'h80 + 8'($urandom_range(0, 15));
            ch_val[c]  = $urandom_range(0, 255);
        end
        repeat (2) tick();
        sample();
        tests_run++;
        if (if_a.valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid got %b want 0", if_a.valid);
        end
        tests_run++;
        if (busy !== 1'b0 || busy_b !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy got %b/%b want 0/0", busy, busy_b);
        end
        tests_run++;
        if (ack !== 3'b000 || ack_b !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ack got %b/%b want 000/000", ack, ack_b);
        end
        clear_queues();
        reset = 1'b0;
        run_fields(1, 1'b0, 1'b0, to);
        tests_run++;
        if (to || ack_q.size() < 1 || ack_q[0] !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_grant got %b want 001 (timeout=%0d)",
                     (ack_q.size() > 0) ? ack_q[0] : 3'bxxx, to);
        end
        got = (byte_q.size() > 0) ? byte_q[0] : 9'bx;
        tests_run++;
        if (got !== {1'b0, ch_addr[0]}) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_cursor got %h want %h", got, {1'b0, ch_addr[0]});
        end
        model_rr = 1;
    endtask

    task automatic test_single_field();
        bit         to;
        logic [8:0] got;
        logic [8:0] want [4];
        want = '{9'h089, 9'h132, 9'h130, 9'h137};
        clear_queues();
        ch_addr[1] = 8'h89;
        ch_val[1]  = 207;
        req        = 3'b010;
        run_fields(1, 1'b0, 1'b0, to);
        tests_run++;
        if (to || byte_q.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL single_count got %0d bytes want 4 (timeout=%0d)", byte_q.size(), to);
        end
        for (int k = 0; k < 4; k++) begin
            got = (k < byte_q.size()) ? byte_q[k] : 9'bx;
            tests_run++;
            if (got !== want[k]) begin
                tests_failed++;
                $display("[TB] FAIL single_byte%0d got %h want %h", k, got, want[k]);
            end
            got = (k < blank_q.size()) ? blank_q[k] : 9'bx;
            tests_run++;
            if (got !== want[k]) begin
                tests_failed++;
                $display("[TB] FAIL single_blank_byte%0d got %h want %h", k, got, want[k]);
            end
        end
        tests_run++;
        if (ack_q.size() != 1 || ack_q[0] !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL single_ack got %0d acks first %b want 1 ack 010",
                     ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : 3'bxxx);
        end
        model_rr = 2;
    endtask

    task automatic test_round_robin();
        bit         to;
        int         nf;
        logic [8:0] got;
        logic [2:0] want_ack;
        logic [2:0] got_ack;
        field_t     e;
        nf = 6;
        clear_queues();
        for (int c = 0; c < 3; c++) begin
            ch_addr[c] = 8'hC0 + 8'($urandom_range(0, 15));
            ch_val[c]  = $urandom_range(0, 255);
        end
        req = 3'b111;
        run_fields(nf, 1'b1, 1'b0, to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("[TB] FAIL rr_timeout got %0d acks want %0d", ack_q.size(), nf);
        end
        for (int i = 0; i < nf; i++) begin
            want_ack = 3'(1 << model_rr);
            got_ack  = (i < ack_q.size()) ? ack_q[i] : 3'bxxx;
            tests_run++;
            if (got_ack !== want_ack) begin
                tests_failed++;
                $display("[TB] FAIL rr_order field %0d got %b want %b", i, got_ack, want_ack);
            end
            model_rr = (model_rr + 1) % 3;
            if (i < exp_q.size()) begin
                e = exp_q[i];
                for (int k = 0; k < 4; k++) begin
                    got = (4 * i + k < byte_q.size()) ? byte_q[4 * i + k] : 9'bx;
                    tests_run++;
                    if (got !== model_byte(e.a, e.v, k, 1'b0)) begin
                        tests_failed++;
                        $display("[TB] FAIL rr_byte f%0d k%0d got %h want %h", i, k, got,
                                 model_byte(e.a, e.v, k, 1'b0));
                    end
                    got = (4 * i + k < blank_q.size()) ? blank_q[4 * i + k] : 9'bx;
                    tests_run++;
                    if (got !== model_byte(e.a, e.v, k, 1'b1)) begin
                        tests_failed++;
                        $display("[TB] FAIL rr_blank f%0d k%0d got %h want %h", i, k, got,
                                 model_byte(e.a, e.v, k, 1'b1));
                    end
                end
                if (i > 0 && i < ack_t.size()) begin
                    tests_run++;
                    if (ack_t[i] - ack_t[i-1] != 7 + e.v / 100 + (e.v / 10) % 10) begin
                        tests_failed++;
                        $display("[TB] FAIL rr_spacing f%0d value %0d got %0d cycles want %0d", i, e.v,
                                 ack_t[i] - ack_t[i-1], 7 + e.v / 100 + (e.v / 10) % 10);
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        int         c;
        int         guard;
        bit         prev_stall;
        logic [8:0] prev;
        logic [8:0] got;
        c          = model_rr;
        guard      = 0;
        prev_stall = 1'b0;
        prev       = '0;
        clear_queues();
        ch_addr[c] = 8'h40 + 8'($urandom_range(0, 15));
        ch_val[c]  = 5;
        req        = 3'(1 << c);
        while (ack_q.size() == 0 && guard < 300) begin
            tick();
            ready = 1'($urandom_range(0, 1));
            sample();
            if (prev_stall) begin
                tests_run++;
                if (if_a.valid !== 1'b1 || {if_a.rs, if_a.data} !== prev) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_hold got v=%b %h want v=1 %h",
                             if_a.valid, {if_a.rs, if_a.data}, prev);
                end
            end
            prev_stall = (if_a.valid === 1'b1) && !ready;
            prev       = {if_a.rs, if_a.data};
            guard++;
        end
        tick();
        req   = '0;
        ready = 1'b1;
        tests_run++;
        if (guard >= 300 || byte_q.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL stall_count got %0d bytes want 4", byte_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            got = (k < byte_q.size()) ? byte_q[k] : 9'bx;
            tests_run++;
            if (got !== model_byte(ch_addr[c], 5, k, 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL stall_byte%0d got %h want %h", k, got, model_byte(ch_addr[c], 5, k, 1'b0));
            end
            got = (k < blank_q.size()) ? blank_q[k] : 9'bx;
            tests_run++;
            if (got !== model_byte(ch_addr[c], 5, k, 1'b1)) begin
                tests_failed++;
                $display("[TB] FAIL stall_blank%0d got %h want %h", k, got, model_byte(ch_addr[c], 5, k, 1'b1));
            end
        end
        model_rr = (c + 1) % 3;
    endtask

    task automatic test_sample_hold();
        int         c;
        int         guard;
        logic [8:0] got;
        c     = model_rr;
        guard = 0;
        clear_queues();
        ch_addr[c] = 8'h8A;
        ch_val[c]  = 42;
        req        = 3'(1 << c);
        ready      = 1'b1;
        do begin
            tick();
            sample();
            guard++;
        end while (busy !== 1'b1 && guard < 10);
        tick();
        ch_val[c] = 99;
        while (ack_q.size() == 0 && guard < 60) begin
            tick();
            sample();
            guard++;
        end
        tick();
        req = '0;
        tests_run++;
        if (guard >= 60) begin
            tests_failed++;
            $display("[TB] FAIL hold_timeout got no ack want ack");
        end
        for (int k = 0; k < 4; k++) begin
            got = (k < byte_q.size()) ? byte_q[k] : 9'bx;
            tests_run++;
            if (got !== model_byte(8'h8A, 42, k, 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL hold_byte%0d got %h want %h", k, got, model_byte(8'h8A, 42, k, 1'b0));
            end
            got = (k < blank_q.size()) ? blank_q[k] : 9'bx;
            tests_run++;
            if (got !== model_byte(8'h8A, 42, k, 1'b1)) begin
                tests_failed++;
                $display("[TB] FAIL hold_blank%0d got %h want %h", k, got, model_byte(8'h8A, 42, k, 1'b1));
            end
        end
        model_rr = (c + 1) % 3;
    endtask

    task automatic test_values();
        int         vals [7];
        int         c;
        int         v;
        bit         to;
        logic [8:0] got;
        vals = '{0, 9, 10, 99, 100, 199, 255};
        for (int i = 0; i < 7; i++) begin
            c = $urandom_range(0, 2);
            v = vals[i];
            clear_queues();
            ch_addr[c] = 8'h80 + 8'($urandom_range(0, 63));
            ch_val[c]  = v;
            req        = 3'(1 << c);
            run_fields(1, 1'b0, 1'b0, to);
            tests_run++;
            if (to || ack_q.size() != 1 || ack_q[0] !== 3'(1 << c)) begin
                tests_failed++;
                $display("[TB] FAIL value_ack v=%0d got %0d acks want one on ch%0d", v, ack_q.size(), c);
            end
            for (int k = 0; k < 4; k++) begin
                got = (k < byte_q.size()) ? byte_q[k] : 9'bx;
                tests_run++;
                if (got !== model_byte(ch_addr[c], v, k, 1'b0)) begin
                    tests_failed++;
                    $display("[TB] FAIL value_byte v=%0d k%0d got %h want %h", v, k, got,
                             model_byte(ch_addr[c], v, k, 1'b0));
                end
                got = (k < blank_q.size()) ? blank_q[k] : 9'bx;
                tests_run++;
                if (got !== model_byte(ch_addr[c], v, k, 1'b1)) begin
                    tests_failed++;
                    $display("[TB] FAIL value_blank v=%0d k%0d got %h want %h", v, k, got,
                             model_byte(ch_addr[c], v, k, 1'b1));
                end
            end
            tests_run++;
            if (busy_cnt != v / 100 + (v / 10) % 10 + 5) begin
                tests_failed++;
                $display("[TB] FAIL value_busy_cycles v=%0d got %0d want %0d", v, busy_cnt,
                         v / 100 + (v / 10) % 10 + 5);
            end
            model_rr = (c + 1) % 3;
        end
    endtask

    task automatic test_reset_mid();
        bit         to;
        int         guard;
        logic [8:0] got;
        clear_queues();
        ch_val[0] = $urandom_range(0, 255);
        req       = 3'b001;
        run_fields(1, 1'b0, 1'b0, to);
        clear_queues();
        ch_val[2] = $urandom_range(0, 255);
        req       = 3'b100;
        ready     = 1'b1;
        guard     = 0;
        while (byte_q.size() < 2 && guard < 40) begin
            tick();
            sample();
            guard++;
        end
        tests_run++;
        if (guard >= 40) begin
            tests_failed++;
            $display("[TB] FAIL midreset_reach got %0d bytes want 2", byte_q.size());
        end
        tick();
        reset = 1'b1;
        ready = 1'b0;
        req   = '0;
        sample();
        tick();
        sample();
        tests_run++;
        if (if_a.valid !== 1'b0 || busy !== 1'b0 || ack !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs got v=%b busy=%b ack=%b want 0/0/000",
                     if_a.valid, busy, ack);
        end
        tests_run++;
        if (byte_q.size() != 2 || ack_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_dropped got %0d bytes %0d acks want 2 bytes 0 acks",
                     byte_q.size(), ack_q.size());
        end
        tick();
        reset = 1'b0;
        req   = 3'b011;
        ready = 1'b1;
        clear_queues();
        run_fields(1, 1'b0, 1'b0, to);
        tests_run++;
        if (to || ack_q.size() != 1 || ack_q[0] !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL midreset_restart got %b want 001",
                     (ack_q.size() > 0) ? ack_q[0] : 3'bxxx);
        end
        got = (byte_q.size() > 0) ? byte_q[0] : 9'bx;
        tests_run++;
        if (got !== {1'b0, ch_addr[0]}) begin
            tests_failed++;
            $display("[TB] FAIL midreset_cursor got %h want %h", got, {1'b0, ch_addr[0]});
        end
        model_rr = 1;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ch_addr[c] = 8'h80;
            ch_val[c]  = 0;
        end
        test_reset();
        test_single_field();
        test_round_robin();
        test_stall();
        test_sample_hold();
        test_values();
        test_reset_mid();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
